// File: rtl/usb_frame_parser.sv
// usb_frame_parser: splits the openHPSDR protocol-1 512-byte USB frame stream
// (3 sync bytes, 5 C&C bytes, 63 eight-byte sample slots) into one command
// strobe per frame and one TX sample strobe per slot.
module usb_frame_parser #(
  parameter logic [7:0] SYNC_BYTE = 8'h7F,
  parameter int         SLOTS     = 63,
  parameter int         TIMEOUT   = 1024
) (
  input  logic        rx_clock,
  input  logic        rx_reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_enable,
  output logic        cmd_valid,
  output logic [6:0]  cmd_addr,
  output logic        cmd_ptt,
  output logic [31:0] cmd_data,
  output logic        smp_valid,
  output logic [15:0] smp_left,
  output logic [15:0] smp_right,
  output logic [15:0] smp_i,
  output logic [15:0] smp_q,
  output logic        in_sync,
  output logic [7:0]  sync_err_cnt,
  output logic [15:0] frame_cnt
);

  localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    ST_HUNT = 3'd0,
    ST_S1   = 3'd1,
    ST_S2   = 3'd2,
    ST_CC   = 3'd3,
    ST_DATA = 3'd4,
    ST_S0   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          cc_idx_q, cc_idx_d;
  logic [2:0]          byte_idx_q, byte_idx_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic [31:0]         cc_sr_q, cc_sr_d;
  logic [55:0]         slot_sr_q, slot_sr_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic [6:0]          cmd_addr_q, cmd_addr_d;
  logic                cmd_ptt_q, cmd_ptt_d;
  logic [31:0]         cmd_data_q, cmd_data_d;
  logic                smp_valid_q, smp_valid_d;
  logic [15:0]         smp_left_q, smp_left_d;
  logic [15:0]         smp_right_q, smp_right_d;
  logic [15:0]         smp_i_q, smp_i_d;
  logic [15:0]         smp_q_q, smp_q_d;
  logic                in_sync_q, in_sync_d;
  logic [7:0]          err_cnt_q, err_cnt_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;

  logic                sync_err;
  logic                sync_match;
  logic [39:0]         cc_word;
  logic [63:0]         slot_word;
  logic [15:0]         lane [4];

  assign sync_match = (rx_data == SYNC_BYTE);
  // The C&C and slot words as they will look once the current byte is shifted in.
  assign cc_word    = {cc_sr_q, rx_data};
  assign slot_word  = {slot_sr_q, rx_data};

  // Slot word lanes in wire order: left, right, I, Q (each high byte first).
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = slot_word[63-16*gi -: 16];
    end
  endgenerate

  // Next-state, field capture, strobes, idle timeout and error accounting.
  always_comb begin
    state_d     = state_q;
    cc_idx_d    = cc_idx_q;
    byte_idx_d  = byte_idx_q;
    slot_d      = slot_q;
    idle_d      = idle_q;
    cc_sr_d     = cc_sr_q;
    slot_sr_d   = slot_sr_q;
    cmd_valid_d = 1'b0;
    cmd_addr_d  = cmd_addr_q;
    cmd_ptt_d   = cmd_ptt_q;
    cmd_data_d  = cmd_data_q;
    smp_valid_d = 1'b0;
    smp_left_d  = smp_left_q;
    smp_right_d = smp_right_q;
    smp_i_d     = smp_i_q;
    smp_q_d     = smp_q_q;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    sync_err    = 1'b0;

    if (rx_enable) begin
      idle_d = '0;
      case (state_q)
        ST_HUNT: begin
          if (sync_match) state_d = ST_S1;
        end
        ST_S1: begin
          if (sync_match) state_d = ST_S2;
          else begin
            state_d  = ST_HUNT;
            sync_err = 1'b1;
          end
        end
        ST_S2: begin
          if (sync_match) begin
            state_d  = ST_CC;
            cc_idx_d = 3'd0;
          end else begin
            state_d  = ST_HUNT;
            sync_err = 1'b1;
          end
        end
        ST_CC: begin
          cc_sr_d = cc_word[31:0];
          if (cc_idx_q == 3'd4) begin
            cmd_valid_d = 1'b1;
            cmd_addr_d  = cc_word[39:33];
            cmd_ptt_d   = cc_word[32];
            cmd_data_d  = cc_word[31:0];
            state_d     = ST_DATA;
            cc_idx_d    = 3'd0;
            byte_idx_d  = 3'd0;
            slot_d      = '0;
          end else begin
            cc_idx_d = cc_idx_q + 3'd1;
          end
        end
        ST_DATA: begin
          slot_sr_d = slot_word[55:0];
          if (byte_idx_q == 3'd7) begin
            smp_valid_d = 1'b1;
            smp_left_d  = lane[0];
            smp_right_d = lane[1];
            smp_i_d     = lane[2];
            smp_q_d     = lane[3];
            byte_idx_d  = 3'd0;
            if (slot_q == SLOT_W'(SLOTS - 1)) begin
              state_d     = ST_S0;
              slot_d      = '0;
              frame_cnt_d = frame_cnt_q + 16'd1;
            end else begin
              slot_d = slot_q + 1'b1;
            end
          end else begin
            byte_idx_d = byte_idx_q + 3'd1;
          end
        end
        ST_S0: begin
          if (sync_match) state_d = ST_S1;
          else begin
            state_d  = ST_HUNT;
            sync_err = 1'b1;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end else if (state_q != ST_HUNT && state_q != ST_S0) begin
      // A stalled mid-frame stream is abandoned once the idle budget runs out.
      if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
        state_d    = ST_HUNT;
        sync_err   = 1'b1;
        idle_d     = '0;
        cc_idx_d   = 3'd0;
        byte_idx_d = 3'd0;
        slot_d     = '0;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end

    if (sync_err && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    in_sync_d = (state_d != ST_HUNT);
  end

  // State and output registers; reset discards any partial frame.
  always_ff @(posedge rx_clock) begin
    if (rx_reset) begin
      state_q     <= ST_HUNT;
      cc_idx_q    <= '0;
      byte_idx_q  <= '0;
      slot_q      <= '0;
      idle_q      <= '0;
      cc_sr_q     <= '0;
      slot_sr_q   <= '0;
      cmd_valid_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_ptt_q   <= 1'b0;
      cmd_data_q  <= '0;
      smp_valid_q <= 1'b0;
      smp_left_q  <= '0;
      smp_right_q <= '0;
      smp_i_q     <= '0;
      smp_q_q     <= '0;
      in_sync_q   <= 1'b0;
      err_cnt_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cc_idx_q    <= cc_idx_d;
      byte_idx_q  <= byte_idx_d;
      slot_q      <= slot_d;
      idle_q      <= idle_d;
      cc_sr_q     <= cc_sr_d;
      slot_sr_q   <= slot_sr_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_ptt_q   <= cmd_ptt_d;
      cmd_data_q  <= cmd_data_d;
      smp_valid_q <= smp_valid_d;
      smp_left_q  <= smp_left_d;
      smp_right_q <= smp_right_d;
      smp_i_q     <= smp_i_d;
      smp_q_q     <= smp_q_d;
      in_sync_q   <= in_sync_d;
      err_cnt_q   <= err_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign cmd_valid    = cmd_valid_q;
  assign cmd_addr     = cmd_addr_q;
  assign cmd_ptt      = cmd_ptt_q;
  assign cmd_data     = cmd_data_q;
  assign smp_valid    = smp_valid_q;
  assign smp_left     = smp_left_q;
  assign smp_right    = smp_right_q;
  assign smp_i        = smp_i_q;
  assign smp_q        = smp_q_q;
  assign in_sync      = in_sync_q;
  assign sync_err_cnt = err_cnt_q;
  assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_usb_frame_parser.sv
// tb_usb_frame_parser: table of C&C headers driven as full frames, plus
// hand-written sequences for sync errors, timeout, mid-frame reset and
// error-counter saturation. Expected pulses are queued when the completing
// byte is driven and popped when the DUT strobes.
module tb_usb_frame_parser;

  localparam logic [7:0] SYNC = 8'h7F;

  logic        rx_clock = 1'b0;
  logic        rx_reset;
  logic [7:0]  rx_data;
  logic        rx_enable;
  logic        cmd_valid;
  logic [6:0]  cmd_addr;
  logic        cmd_ptt;
  logic [31:0] cmd_data;
  logic        smp_valid;
  logic [15:0] smp_left, smp_right, smp_i, smp_q;
  logic        in_sync;
  logic [7:0]  sync_err_cnt;
  logic [15:0] frame_cnt;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int cmd_seen = 0;
  int smp_seen = 0;

  typedef struct {
    logic [6:0]  addr;
    logic        ptt;
    logic [31:0] data;
    int          cyc;
  } cmd_exp_t;

  typedef struct {
    logic [15:0] l, r, i, q;
    int          cyc;
  } smp_exp_t;

  typedef struct {
    logic [7:0]  c0;
    logic [31:0] c14;
    int          gap;
    logic [6:0]  exp_addr;
    logic        exp_ptt;
    logic [31:0] exp_data;
  } vec_t;

  cmd_exp_t cmd_sb[$];
  smp_exp_t smp_sb[$];
  vec_t     vecs[4];

  usb_frame_parser dut (
    .rx_clock    (rx_clock),
    .rx_reset    (rx_reset),
    .rx_data     (rx_data),
    .rx_enable   (rx_enable),
    .cmd_valid   (cmd_valid),
    .cmd_addr    (cmd_addr),
    .cmd_ptt     (cmd_ptt),
    .cmd_data    (cmd_data),
    .smp_valid   (smp_valid),
    .smp_left    (smp_left),
    .smp_right   (smp_right),
    .smp_i       (smp_i),
    .smp_q       (smp_q),
    .in_sync     (in_sync),
    .sync_err_cnt(sync_err_cnt),
    .frame_cnt   (frame_cnt)
  );

  always #5 rx_clock = ~rx_clock;

  always @(posedge rx_clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and score any strobe present there.
  task automatic tick();
    cmd_exp_t ce;
    smp_exp_t se;
    @(negedge rx_clock);
    if (cmd_valid || smp_valid) begin
      checks++;
      if (cmd_valid && smp_valid) begin
        failures++;
        $display("FAIL both_strobes: got cmd_valid=1 smp_valid=1 expected at most one");
      end
    end
    if (cmd_valid) begin
      cmd_seen++;
      checks++;
      if (cmd_sb.size() == 0) begin
        failures++;
        $display("FAIL cmd_unexpected: got cmd_valid at cycle %0d expected none", cyc);
      end else begin
        ce = cmd_sb.pop_front();
        if (cmd_addr !== ce.addr || cmd_ptt !== ce.ptt || cmd_data !== ce.data ||
            cyc != ce.cyc + 1) begin
          failures++;
          $display("FAIL cmd_fields: got addr=%h ptt=%b data=%h cyc=%0d expected addr=%h ptt=%b data=%h cyc=%0d",
                   cmd_addr, cmd_ptt, cmd_data, cyc, ce.addr, ce.ptt, ce.data, ce.cyc + 1);
        end
      end
    end
    if (smp_valid) begin
      smp_seen++;
      checks++;
      if (smp_sb.size() == 0) begin
        failures++;
        $display("FAIL smp_unexpected: got smp_valid at cycle %0d expected none", cyc);
      end else begin
        se = smp_sb.pop_front();
        if (smp_left !== se.l || smp_right !== se.r || smp_i !== se.i || smp_q !== se.q ||
            cyc != se.cyc + 1) begin
          failures++;
          $display("FAIL smp_fields: got %h %h %h %h cyc=%0d expected %h %h %h %h cyc=%0d",
                   smp_left, smp_right, smp_i, smp_q, cyc, se.l, se.r, se.i, se.q, se.cyc + 1);
        end
      end
    end
  endtask

  task automatic drive(input logic [7:0] b);
    tick();
    rx_data   = b;
    rx_enable = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      rx_enable = 1'b0;
      rx_data   = 8'($urandom);
    end
  endtask

  task automatic do_reset();
    tick();
    rx_reset  = 1'b1;
    rx_enable = 1'b0;
    tick();
    rx_reset  = 1'b0;
  endtask

  // C&C bytes plus nslots sample slots; slot n = {n,0,n,1,n,2,n,3}.
  task automatic send_body(input logic [7:0] c0, input logic [31:0] c14, input int gap,
                           input bit exp_on, input logic [6:0] ea, input logic ep,
                           input logic [31:0] ed, input int nslots);
    cmd_exp_t ce;
    smp_exp_t se;
    logic [7:0] nb;
    drive(c0);          idle(gap);
    drive(c14[31:24]);  idle(gap);
    drive(c14[23:16]);  idle(gap);
    drive(c14[15:8]);   idle(gap);
    drive(c14[7:0]);
    if (exp_on) begin
      ce.addr = ea; ce.ptt = ep; ce.data = ed; ce.cyc = cyc;
      cmd_sb.push_back(ce);
    end
    idle(gap);
    for (int n = 0; n < nslots; n++) begin
      nb = 8'(n);
      for (int k = 0; k < 8; k++) begin
        if (k % 2 == 0) drive(nb);
        else            drive(8'(k / 2));
        if (k == 7 && exp_on) begin
          se.l = {nb, 8'h00}; se.r = {nb, 8'h01};
          se.i = {nb, 8'h02}; se.q = {nb, 8'h03};
          se.cyc = cyc;
          smp_sb.push_back(se);
        end
        idle(gap);
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] c0, input logic [31:0] c14, input int gap,
                            input logic [6:0] ea, input logic ep, input logic [31:0] ed);
    drive(SYNC); idle(gap);
    drive(SYNC); idle(gap);
    drive(SYNC); idle(gap);
    send_body(c0, c14, gap, 1'b1, ea, ep, ed, 63);
  endtask

  initial begin
    int c_base, s_base;

    vecs[0] = '{c0: 8'h05, c14: 32'h12345678, gap: 0, exp_addr: 7'h02, exp_ptt: 1'b1, exp_data: 32'h12345678};
    vecs[1] = '{c0: 8'h05, c14: 32'h12345678, gap: 1, exp_addr: 7'h02, exp_ptt: 1'b1, exp_data: 32'h12345678};
    vecs[2] = '{c0: 8'hFE, c14: 32'hDEADBEEF, gap: 0, exp_addr: 7'h7F, exp_ptt: 1'b0, exp_data: 32'hDEADBEEF};
    vecs[3] = '{c0: 8'h81, c14: 32'h00000001, gap: 2, exp_addr: 7'h40, exp_ptt: 1'b1, exp_data: 32'h00000001};

    rx_reset  = 1'b1;
    rx_enable = 1'b0;
    rx_data   = 8'h00;
    for (int k = 0; k < 3; k++) tick();
    chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst_cmd_data",  cmd_data, 32'd0);
    chk("rst_cmd_addr",  32'({cmd_addr, cmd_ptt}), 32'd0);
    chk("rst_smp_valid", 32'(smp_valid), 32'd0);
    chk("rst_smp",       32'(smp_left | smp_right | smp_i | smp_q), 32'd0);
    chk("rst_in_sync",   32'(in_sync), 32'd0);
    chk("rst_err",       32'(sync_err_cnt), 32'd0);
    chk("rst_frames",    32'(frame_cnt), 32'd0);
    rx_reset = 1'b0;

    // Table: one full frame per header, varying the enable duty cycle.
    for (int v = 0; v < 4; v++) begin
      do_reset();
      c_base = cmd_seen; s_base = smp_seen;
      send_frame(vecs[v].c0, vecs[v].c14, vecs[v].gap,
                 vecs[v].exp_addr, vecs[v].exp_ptt, vecs[v].exp_data);
      idle(1);
      chk("vec_frame_cnt", 32'(frame_cnt), 32'd1);
      chk("vec_err_cnt",   32'(sync_err_cnt), 32'd0);
      chk("vec_in_sync",   32'(in_sync), 32'd1);
      chk("vec_cmd_count", 32'(cmd_seen - c_base), 32'd1);
      chk("vec_smp_count", 32'(smp_seen - s_base), 32'd63);
      chk("vec_pending",   32'(cmd_sb.size() + smp_sb.size()), 32'd0);
      chk("vec_cmd_hold",  cmd_data, vecs[v].exp_data);
      chk("vec_smp_hold",  32'({smp_left, smp_q}), 32'h3E003E03);
      $display("vec %0d: c0=%h gap=%0d frames=%0d cmd=%0d smp=%0d",
               v, vecs[v].c0, vecs[v].gap, frame_cnt, cmd_seen - c_base, smp_seen - s_base);
    end

    // Broken sync run 7F 7F 00, then a valid frame.
    do_reset();
    c_base = cmd_seen;
    drive(SYNC); drive(SYNC); drive(8'h00);
    idle(1);
    chk("bad_sync_err",     32'(sync_err_cnt), 32'd1);
    chk("bad_sync_in_sync", 32'(in_sync), 32'd0);
    chk("bad_sync_no_cmd",  32'(cmd_seen - c_base), 32'd0);
    send_frame(8'h05, 32'h12345678, 0, 7'h02, 1'b1, 32'h12345678);
    idle(1);
    chk("after_bad_frames", 32'(frame_cnt), 32'd1);
    chk("after_bad_err",    32'(sync_err_cnt), 32'd1);
    chk("after_bad_cmd",    32'(cmd_seen - c_base), 32'd1);
    $display("seq bad_sync: err=%0d frames=%0d", sync_err_cnt, frame_cnt);

    // Back-to-back frames, second with corrupted first sync byte.
    do_reset();
    c_base = cmd_seen; s_base = smp_seen;
    send_frame(8'h05, 32'h12345678, 0, 7'h02, 1'b1, 32'h12345678);
    drive(8'h7E);
    idle(1);
    chk("corrupt_err",     32'(sync_err_cnt), 32'd1);
    chk("corrupt_in_sync", 32'(in_sync), 32'd0);
    drive(SYNC); drive(SYNC);
    send_body(8'h05, 32'h12345678, 0, 1'b0, 7'h00, 1'b0, 32'h0, 63);
    idle(1);
    chk("corrupt_cmd_count", 32'(cmd_seen - c_base), 32'd1);
    chk("corrupt_smp_count", 32'(smp_seen - s_base), 32'd63);
    chk("corrupt_frames",    32'(frame_cnt), 32'd1);
    chk("corrupt_err_end",   32'(sync_err_cnt), 32'd2);
    $display("seq corrupt: err=%0d frames=%0d in_sync=%0d", sync_err_cnt, frame_cnt, in_sync);

    // Stall after 3 slots until the idle timeout fires.
    do_reset();
    drive(SYNC); drive(SYNC); drive(SYNC);
    send_body(8'h05, 32'h12345678, 0, 1'b1, 7'h02, 1'b1, 32'h12345678, 3);
    idle(1024);
    chk("tmo_edge_in_sync", 32'(in_sync), 32'd1);
    chk("tmo_edge_err",     32'(sync_err_cnt), 32'd0);
    idle(1);
    chk("tmo_in_sync", 32'(in_sync), 32'd0);
    chk("tmo_err",     32'(sync_err_cnt), 32'd1);
    send_frame(8'h05, 32'h12345678, 0, 7'h02, 1'b1, 32'h12345678);
    idle(1);
    chk("tmo_frames",  32'(frame_cnt), 32'd1);
    chk("tmo_pending", 32'(cmd_sb.size() + smp_sb.size()), 32'd0);
    $display("seq timeout: err=%0d frames=%0d", sync_err_cnt, frame_cnt);

    // Reset mid-slot, then confirm nothing is emitted from leftover data.
    do_reset();
    drive(SYNC); drive(SYNC); drive(SYNC);
    send_body(8'h05, 32'h12345678, 0, 1'b1, 7'h02, 1'b1, 32'h12345678, 2);
    drive(8'h02); drive(8'h00); drive(8'h02); drive(8'h01);
    tick();
    rx_reset  = 1'b1;
    rx_data   = 8'h02;
    tick();
    rx_reset  = 1'b0;
    rx_enable = 1'b0;
    chk("mid_rst_cmd",     32'({cmd_valid, cmd_addr, cmd_ptt}), 32'd0);
    chk("mid_rst_cmddata", cmd_data, 32'd0);
    chk("mid_rst_smp",     32'({smp_valid, smp_left}), 32'd0);
    chk("mid_rst_smp2",    32'(smp_right | smp_i | smp_q), 32'd0);
    chk("mid_rst_state",   32'({in_sync, sync_err_cnt, frame_cnt}), 32'd0);
    s_base = smp_seen;
    drive(8'h02); drive(8'h02); drive(8'h02); drive(8'h03);
    for (int k = 0; k < 8; k++) drive((k % 2 == 0) ? 8'h03 : 8'(k / 2));
    idle(1);
    chk("mid_rst_no_smp", 32'(smp_seen - s_base), 32'd0);
    chk("mid_rst_hunt",   32'(in_sync), 32'd0);
    $display("seq mid_reset: smp after reset=%0d", smp_seen - s_base);

    // Drive 300 sync errors; the counter must stop at 255.
    for (int e = 0; e < 300; e++) begin
      drive(SYNC);
      drive(8'h00);
      if (e == 253) begin
        idle(1);
        chk("sat_254", 32'(sync_err_cnt), 32'd254);
      end
    end
    idle(1);
    chk("sat_255", 32'(sync_err_cnt), 32'd255);
    chk("sat_pending", 32'(cmd_sb.size() + smp_sb.size()), 32'd0);
    $display("seq saturate: err=%0d", sync_err_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
